// File: rtl/symbol_decoder.sv
// rtl/symbol_decoder.sv - multi-symbol arithmetic decoder: icdf search against a registered CDF memory, bitwise renormalisation
module symbol_decoder #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic                    sym_req,
    input  logic [SYMBOL_WIDTH:0]   nsyms,
    output logic                    sym_req_ready,
    output logic [SYMBOL_WIDTH-1:0] icdf_addr,
    input  logic [RANGE_WIDTH-1:0]  icdf_data,
    output logic [SYMBOL_WIDTH-1:0] sym_out,
    output logic                    sym_valid
);

    localparam int RW   = RANGE_WIDTH;
    localparam int SW   = SYMBOL_WIDTH;
    localparam int CW   = RW + 1;
    localparam int PW   = 2 * RW;
    localparam int CNTW = $clog2(RW);

    localparam logic [RW-1:0]   RNG_INIT  = {1'b1, {(RW-1){1'b0}}};
    localparam logic [SW:0]     N_ONE     = {{SW{1'b0}}, 1'b1};
    localparam logic [SW:0]     N_MAX     = {1'b1, {SW{1'b0}}};
    localparam logic [SW:0]     ADDR_LAST = {1'b0, {SW{1'b1}}};
    localparam logic [SW-1:0]   ADDR_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] FILL_LAST = CNTW'(RW - 2);

    typedef enum logic [2:0] {
        UNINIT = 3'd0,
        FILL   = 3'd1,
        IDLE   = 3'd2,
        SEARCH = 3'd3,
        RENORM = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rng_q, rng_d;
    logic [RW-1:0]   val_q, val_d;
    logic [RW-1:0]   prev_q, prev_d;
    logic [SW:0]     k_q, k_d;
    logic [SW:0]     n_q, n_d;
    logic [SW-1:0]   sym_q, sym_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [SW:0]     n_sat;
    logic [SW:0]     rem;
    logic [PW-1:0]   prod;
    logic [CW-1:0]   cur;
    logic [RW-1:0]   stop_rng;
    logic [SW-1:0]   addr_next;
    logic            last_k;
    logic            val_lt_cur;

    always_comb begin
        if (nsyms <= N_ONE) begin
            n_sat = N_ONE;
        end else if (nsyms > N_MAX) begin
            n_sat = N_MAX;
        end else begin
            n_sat = nsyms;
        end
    end

    // Boundary for symbol k: scaled icdf plus the minimum-probability floor of the symbols above k.
    assign prod       = PW'(rng_q >> 8) * PW'(icdf_data >> 6);
    assign rem        = n_q - k_q - N_ONE;
    assign last_k     = (k_q == n_q - N_ONE);
    assign cur        = last_k ? '0 : CW'(prod >> 1) + CW'({rem, 2'b00});
    assign val_lt_cur = {1'b0, val_q} < cur;
    assign stop_rng   = prev_q - cur[RW-1:0];
    assign addr_next  = (k_q >= ADDR_LAST) ? ADDR_LAST[SW-1:0] : k_q[SW-1:0] + ADDR_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNINIT;
            rng_q   <= RNG_INIT;
            val_q   <= '0;
            prev_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            sym_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rng_q   <= rng_d;
            val_q   <= val_d;
            prev_q  <= prev_d;
            k_q     <= k_d;
            n_q     <= n_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rng_d   = rng_q;
        val_d   = val_q;
        prev_d  = prev_q;
        k_d     = k_q;
        n_d     = n_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        if (init) begin
            state_d = FILL;
            rng_d   = RNG_INIT;
            val_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bit_valid) begin
                        val_d = {val_q[RW-2:0], ~bit_in};
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == FILL_LAST) begin
                            state_d = IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (sym_req) begin
                        n_d     = n_sat;
                        k_d     = '0;
                        prev_d  = rng_q;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (val_lt_cur) begin
                        prev_d = cur[RW-1:0];
                        k_d    = k_q + N_ONE;
                    end else begin
                        sym_d   = k_q[SW-1:0];
                        rng_d   = stop_rng;
                        val_d   = val_q - cur[RW-1:0];
                        state_d = stop_rng[RW-1] ? DONE : RENORM;
                    end
                end
                RENORM: begin
                    if (bit_valid) begin
                        rng_d = {rng_q[RW-2:0], 1'b0};
                        val_d = {val_q[RW-2:0], ~bit_in};
                        if (rng_q[RW-2]) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        bit_ready     = 1'b0;
        sym_req_ready = 1'b0;
        sym_valid     = 1'b0;
        icdf_addr     = '0;
        case (state_q)
            FILL, RENORM: bit_ready     = 1'b1;
            IDLE:         sym_req_ready = 1'b1;
            SEARCH:       icdf_addr     = addr_next;
            DONE:         sym_valid     = 1'b1;
            default:      bit_ready     = 1'b0;
        endcase
    end

    assign sym_out = sym_q;

endmodule

// File: tb/tb_symbol_decoder.sv
// tb/tb_symbol_decoder.sv - directed vectors, abort sequences and encoder round trip for symbol_decoder
module tb_symbol_decoder;
    localparam int RW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset, init, bit_in, bit_valid, sym_req;
    logic [SW:0]   nsyms;
    logic          bit_ready, sym_req_ready, sym_valid;
    logic [SW-1:0] icdf_addr, sym_out;
    logic [RW-1:0] icdf_data;

    always #5 clk = ~clk;

    symbol_decoder #(.RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_req(sym_req), .nsyms(nsyms), .sym_req_ready(sym_req_ready),
        .icdf_addr(icdf_addr), .icdf_data(icdf_data),
        .sym_out(sym_out), .sym_valid(sym_valid)
    );

    int tbl [6][16];
    int ntab [6];
    int sel = 0;
    always @(posedge clk) icdf_data <= RW'(tbl[sel][icdf_addr]);

    bit bs[$];
    bit outq[$];
    int ptr;
    int n_checks = 0;
    int n_fail = 0;
    int addr_tr [32];
    int fill_v0, sv_cnt;
    int elow, erng;

    typedef struct {
        int fill; int t; int ns; int rbit; int stall;
        int e_sym; int e_lat; int e_rng; int e_val;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cur_bit();
        return (ptr < bs.size()) ? bs[ptr] : 1'b0;
    endfunction

    task automatic do_fill(output int cyc);
        @(negedge clk);
        init = 1'b1; sym_req = 1'b0; bit_valid = 1'b0;
        @(negedge clk);
        init = 1'b0; cyc = 1; fill_v0 = int'(dut.val_q); sv_cnt = 0;
        while (!sym_req_ready && cyc < 40) begin
            if (sym_valid) sv_cnt++;
            bit_valid = bit_ready;
            bit_in = cur_bit();
            if (bit_ready) ptr++;
            @(negedge clk);
            cyc++;
        end
        bit_valid = 1'b0;
    endtask

    task automatic decode(input int t, input int ns, input int stall_len, output int sym, output int lat);
        int guard, rn;
        guard = 0;
        while (!sym_req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        sel = t; sym_req = 1'b1; nsyms = (SW+1)'(ns); bit_valid = 1'b0;
        addr_tr[0] = int'(icdf_addr);
        lat = 0; sym = -1; rn = 0;
        while (lat < 80) begin
            @(negedge clk);
            lat++;
            sym_req = 1'b0;
            bit_valid = 1'b0;
            if (lat < 32) addr_tr[lat] = int'(icdf_addr);
            if (sym_valid) begin
                sym = int'(sym_out);
                break;
            end
            if (bit_ready) begin
                if (rn >= stall_len) begin
                    bit_valid = 1'b1;
                    bit_in = cur_bit();
                    ptr++;
                end
                rn++;
            end
        end
    endtask

    // Bench-side encoder: 16-bit low window with carry propagation into the emitted bits.
    task automatic enc_sym(input int t, input int s);
        int n, r, u, v, i;
        n = ntab[t];
        r = erng;
        v = (((r >> 8) * (tbl[t][s] >> 6)) >> 1) + 4 * (n - 1 - s);
        if (s > 0) begin
            u = (((r >> 8) * (tbl[t][s-1] >> 6)) >> 1) + 4 * (n - s);
            elow = elow + r - u;
            r = u - v;
        end else begin
            r = r - v;
        end
        if (elow >= 65536) begin
            elow = elow - 65536;
            i = outq.size() - 1;
            while (i >= 0 && outq[i] == 1'b1) begin
                outq[i] = 1'b0;
                i--;
            end
            if (i >= 0) outq[i] = 1'b1;
        end
        while (r < 32768) begin
            outq.push_back(elow[15]);
            elow = (elow << 1) & 32'hFFFF;
            r = r << 1;
        end
        erng = r;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fc, sym, lat, t, s;
        int unsigned seed;
        int syms [200];
        int tsel [200];
        vec_t v;

        ntab[0] = 2;  tbl[0][0] = 16384; tbl[0][1] = 0;
        ntab[1] = 4;  tbl[1][0] = 24576; tbl[1][1] = 16384; tbl[1][2] = 8192; tbl[1][3] = 0;
        ntab[2] = 8;
        tbl[2][0] = 30000; tbl[2][1] = 26000; tbl[2][2] = 20000; tbl[2][3] = 15000;
        tbl[2][4] = 9000;  tbl[2][5] = 5000;  tbl[2][6] = 2000;  tbl[2][7] = 0;
        ntab[3] = 16;
        for (int k = 0; k < 16; k++) tbl[3][k] = 30720 - 2048 * k;
        ntab[4] = 3;  tbl[4][0] = 31000; tbl[4][1] = 1000; tbl[4][2] = 0;
        ntab[5] = 16;
        for (int k = 0; k < 16; k++) tbl[5][k] = 32000 - 1000 * k;

        //           fill t  ns rbit stall sym lat rng    val
        vecs[0] = '{0, 0, 2,  0, 0, 0,  4,  65520, 65519};
        vecs[1] = '{1, 0, 2,  0, 0, 1,  4,  32776, 1};
        vecs[2] = '{0, 0, 2,  0, 3, 0,  7,  65520, 65519};
        vecs[3] = '{1, 5, 16, 1, 0, 15, 18, 35976, 0};
        vecs[4] = '{0, 0, 0,  0, 0, 0,  2,  32768, 32767};
        vecs[5] = '{1, 5, 20, 1, 0, 15, 18, 35976, 0};
        vecs[6] = '{1, 0, 2,  1, 0, 1,  4,  32776, 0};

        reset = 1'b1; init = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        sym_req = 1'b0; nsyms = '0;
        repeat (2) @(negedge clk);
        check("rst_bit_ready", int'(bit_ready), 0);
        check("rst_sym_req_ready", int'(sym_req_ready), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_sym_out", int'(sym_out), 0);
        check("rst_icdf_addr", int'(icdf_addr), 0);
        check("rst_rng", int'(dut.rng_q), 32768);
        check("rst_val", int'(dut.val_q), 0);
        reset = 1'b0; bit_valid = 1'b1; sym_req = 1'b1;
        @(negedge clk);
        check("uninit_bit_ready", int'(bit_ready), 0);
        check("uninit_req_ready", int'(sym_req_ready), 0);
        bit_valid = 1'b0; sym_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            bs.delete();
            for (int j = 0; j < 15; j++) bs.push_back(v.fill[0]);
            for (int j = 0; j < 4; j++) bs.push_back(v.rbit[0]);
            ptr = 0;
            do_fill(fc);
            check($sformatf("v%0d_fill_cycles", i), fc, 16);
            check($sformatf("v%0d_fill_val", i), int'(dut.val_q), v.fill ? 0 : 32767);
            decode(v.t, v.ns, v.stall, sym, lat);
            check($sformatf("v%0d_sym", i), sym, v.e_sym);
            check($sformatf("v%0d_latency", i), lat, v.e_lat);
            check($sformatf("v%0d_rng", i), int'(dut.rng_q), v.e_rng);
            check($sformatf("v%0d_val", i), int'(dut.val_q), v.e_val);
            if (v.t == 5) begin
                for (int a = 0; a <= 16; a++)
                    check($sformatf("v%0d_addr%0d", i, a), addr_tr[a], (a < 15) ? a : 15);
            end
            @(negedge clk);
            check($sformatf("v%0d_valid_pulse", i), int'(sym_valid), 0);
            check($sformatf("v%0d_sym_hold", i), int'(sym_out), v.e_sym);
            check($sformatf("v%0d_req_ready", i), int'(sym_req_ready), 1);
        end

        // Asynchronous reset while parked in RENORM.
        bs.delete();
        for (int j = 0; j < 15; j++) bs.push_back(1'b1);
        ptr = 0;
        do_fill(fc);
        sel = 0; sym_req = 1'b1; nsyms = 5'd2;
        @(negedge clk);
        sym_req = 1'b0;
        repeat (2) @(negedge clk);
        check("park_bit_ready", int'(bit_ready), 1);
        check("park_sym_out", int'(sym_out), 1);
        #2 reset = 1'b1;
        #1;
        check("async_bit_ready", int'(bit_ready), 0);
        check("async_sym_out", int'(sym_out), 0);
        check("async_req_ready", int'(sym_req_ready), 0);
        check("async_sym_valid", int'(sym_valid), 0);
        check("async_rng", int'(dut.rng_q), 32768);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_bit_ready", int'(bit_ready), 0);

        // init while SEARCH is walking a 16-symbol alphabet.
        bs.delete();
        for (int j = 0; j < 15; j++) bs.push_back(1'b1);
        for (int j = 0; j < 20; j++) bs.push_back(1'b0);
        ptr = 0;
        do_fill(fc);
        sel = 5; sym_req = 1'b1; nsyms = 5'd16;
        @(negedge clk);
        sym_req = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_addr_k4", int'(icdf_addr), 5);
        do_fill(fc);
        check("abort_fill_start_val", fill_v0, 0);
        check("abort_no_valid", sv_cnt, 0);
        check("abort_fill_cycles", fc, 16);
        check("abort_fill_val", int'(dut.val_q), 32767);
        check("abort_ptr", ptr, 30);
        decode(0, 2, 0, sym, lat);
        check("abort_next_sym", sym, 0);
        check("abort_next_latency", lat, 4);

        // Round trip against the bench encoder.
        seed = 32'd12345;
        elow = 0; erng = 32768; outq.delete();
        for (int i = 0; i < 200; i++) begin
            seed = seed * 32'd1103515245 + 32'd12345;
            t = int'((seed >> 16) % 5);
            seed = seed * 32'd1103515245 + 32'd12345;
            s = int'((seed >> 16) % ntab[t]);
            tsel[i] = t;
            syms[i] = s;
            enc_sym(t, s);
        end
        for (int b = 15; b >= 0; b--) outq.push_back(elow[b]);
        bs.delete();
        for (int j = 1; j < outq.size(); j++) bs.push_back(outq[j]);
        ptr = 0;
        do_fill(fc);
        for (int i = 0; i < 200; i++) begin
            decode(tsel[i], ntab[tsel[i]], 0, sym, lat);
            check($sformatf("rt_sym%0d", i), sym, syms[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
